// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Command codes, FSM encodings and clear defaults shared by VRAM blocks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // Bus-side command codes {wr, rd, reg[3:0]}
  localparam logic [5:0] c_cmd_none = 6'b000000;
  localparam logic [5:0] c_cmd_rd   = 6'b010011;
  localparam logic [5:0] c_cmd_wr   = 6'b100011;
  localparam logic [5:0] c_cmd_clr  = 6'b110000;

  // Externally visible state codes
  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_busy = 2'd1;
  localparam logic [1:0] c_state_done = 2'd2;

  // Internal executor FSM encodings
  localparam logic [2:0] c_s_idle   = 3'd0;
  localparam logic [2:0] c_s_issue  = 3'd1;
  localparam logic [2:0] c_s_rdwait = 3'd2;
  localparam logic [2:0] c_s_clear  = 3'd3;
  localparam logic [2:0] c_s_done   = 3'd4;

  localparam int          c_vram_aw            = 14;
  localparam int          c_clear_words_default = 2400;
  localparam logic [15:0] c_clear_fill_default  = 16'h7020;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exec_req_t;

  function automatic logic [1:0] state_code(input logic [2:0] s);
    case (s)
      c_s_idle:                        state_code = c_state_idle;
      c_s_issue, c_s_rdwait, c_s_clear: state_code = c_state_busy;
      c_s_done:                        state_code = c_state_done;
      default:                         state_code = c_state_idle;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_clear_seq.sv
// ============================================================================
// Module : vram_clear_seq
// Brief  : Clear-screen address counter with terminal-word flag
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_clear_seq
  import vga_pkg::*;
#(
  parameter int WORDS = c_clear_words_default,
  parameter int AW    = c_vram_aw
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          step,
  output logic [AW-1:0] count,
  output logic          last
);

  localparam logic [AW-1:0] c_last_idx = (AW)'(WORDS - 1);

  logic [AW-1:0] r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign last  = (r_count == c_last_idx);

endmodule

`default_nettype wire

// File: rtl/vram_exec.sv
// ============================================================================
// Module : vram_exec
// Brief  : Executes read/write/clear commands on single-port VRAM, yielding to video fetch
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_exec
  import vga_pkg::*;
#(
  parameter int          CLEAR_WORDS = c_clear_words_default,
  parameter logic [15:0] CLEAR_FILL  = c_clear_fill_default
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [5:0]  cmd,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [1:0]  state,
  input  logic        vid_rd_en,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic [15:0] mem_dout
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  exec_req_t   r_req;
  logic [15:0] r_rdata;
  logic [15:0] r_vid_hold;
  logic        r_vid_valid;
  logic        w_free;
  logic        w_oor;
  logic        w_accept;
  logic        w_clr_start;
  logic        w_clr_step;
  logic        w_clr_last;
  logic [13:0] w_clr_addr;

  assign w_free   = ~vid_rd_en;
  assign w_oor    = |r_req.addr[15:14];
  assign w_accept = (r_state == c_s_idle) && ((cmd == c_cmd_rd) || (cmd == c_cmd_wr));

  vram_clear_seq #(
    .WORDS (CLEAR_WORDS),
    .AW    (14)
  ) u_clear_seq (
    .clk   (clk),
    .nrst  (nrst),
    .start (w_clr_start),
    .step  (w_clr_step),
    .count (w_clr_addr),
    .last  (w_clr_last)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_s_idle: begin
        if ((cmd == c_cmd_rd) || (cmd == c_cmd_wr)) begin
          w_next = c_s_issue;
        end else if (cmd == c_cmd_clr) begin
          w_next = c_s_clear;
        end
      end
      c_s_issue:  if (w_free) w_next = r_req.wr ? c_s_done : c_s_rdwait;
      c_s_rdwait: w_next = c_s_done;
      c_s_clear:  if (w_free && w_clr_last) w_next = c_s_done;
      c_s_done:   if (cmd == c_cmd_none) w_next = c_s_idle;
      default:    w_next = c_s_idle;
    endcase
  end

  // RAM port is combinational so a video fetch lands exactly one cycle after its request
  always_comb begin
    mem_addr    = '0;
    mem_din     = '0;
    mem_we      = 1'b0;
    w_clr_step  = 1'b0;
    w_clr_start = 1'b0;
    if (nrst) begin
      w_clr_start = (r_state == c_s_idle) && (cmd == c_cmd_clr);
      if (vid_rd_en) begin
        mem_addr = vid_addr;
      end else begin
        case (r_state)
          c_s_issue: begin
            if (!w_oor) begin
              mem_addr = r_req.addr[13:0];
              mem_din  = r_req.wr ? r_req.wdata : 16'h0000;
              mem_we   = r_req.wr;
            end
          end
          c_s_clear: begin
            mem_addr   = w_clr_addr;
            mem_din    = CLEAR_FILL;
            mem_we     = 1'b1;
            w_clr_step = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_req       <= '0;
      r_rdata     <= '0;
      r_vid_valid <= 1'b0;
      r_vid_hold  <= '0;
    end else begin
      if (w_accept) begin
        r_req <= '{wr: (cmd == c_cmd_wr), addr: addr, wdata: wdata};
      end
      if (r_state == c_s_rdwait) begin
        r_rdata <= w_oor ? 16'h0000 : mem_dout;
      end
      r_vid_valid <= vid_rd_en;
      if (r_vid_valid) begin
        r_vid_hold <= mem_dout;
      end
    end
  end

  assign state     = state_code(r_state);
  assign rdata     = r_rdata;
  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_valid ? mem_dout : r_vid_hold;

endmodule

`default_nettype wire

// File: tb/tb_vram_exec.sv
// ============================================================================
// Module : tb_vram_exec
// Brief  : Directed self-checking bench for vram_exec with a behavioural VRAM
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_exec;

  logic        clk = 1'b0;
  logic        nrst;
  logic [5:0]  cmd;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  state;
  logic        vid_rd_en;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic [13:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic [15:0] ram [0:16383];

  int n_pass  = 0;
  int n_total = 0;

  int          wr_cnt   = 0;
  int          viol_cnt = 0;
  int          clr_bad  = 0;
  int          clr_next = 0;
  bit          clr_mode = 1'b0;
  logic [13:0] last_wa  = '0;

  always #5 clk = ~clk;

  vram_exec dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd       (cmd),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .state     (state),
    .vid_rd_en (vid_rd_en),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;
    mem_dout = 16'h0000;
  end

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_din;
      wr_cnt++;
      last_wa = mem_addr;
      if (vid_rd_en) viol_cnt++;
      if (clr_mode) begin
        if (mem_addr !== clr_next[13:0] || mem_din !== 16'h7020) clr_bad++;
        clr_next++;
      end
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic test_reset();
    nrst = 1'b0; cmd = '0; addr = '0; wdata = '0;
    vid_rd_en = 1'b1; vid_addr = 14'h0155;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
    n_total++; if (rdata !== 16'h0) $display("FAIL rst_rdata: got %h want 0000", rdata); else n_pass++;
    n_total++; if (vid_data !== 16'h0) $display("FAIL rst_vid_data: got %h want 0000", vid_data); else n_pass++;
    n_total++; if (vid_valid !== 1'b0) $display("FAIL rst_vid_valid: got %b want 0", vid_valid); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 14'h0) $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); else n_pass++;
    n_total++; if (mem_din !== 16'h0) $display("FAIL rst_mem_din: got %h want 0000", mem_din); else n_pass++;
    @(negedge clk);
    nrst = 1'b1; vid_rd_en = 1'b0; vid_addr = '0;
    @(negedge clk);
  endtask

  task automatic test_write();
    wr_cnt = 0;
    cmd = 6'b100011; addr = 16'h0010; wdata = 16'h7041;
    #1;
    n_total++; if (state !== 2'd0) $display("FAIL wr_state_idle: got %0d want 0", state); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd1) $display("FAIL wr_state_busy: got %0d want 1", state); else n_pass++;
    n_total++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 14'h0010) $display("FAIL wr_mem_addr: got %h want 0010", mem_addr); else n_pass++;
    n_total++; if (mem_din !== 16'h7041) $display("FAIL wr_mem_din: got %h want 7041", mem_din); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd2) $display("FAIL wr_state_done: got %0d want 2", state); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL wr_we_after: got %b want 0", mem_we); else n_pass++;
    cmd = '0;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL wr_state_back: got %0d want 0", state); else n_pass++;
    n_total++; if (wr_cnt !== 1) $display("FAIL wr_count: got %0d want 1", wr_cnt); else n_pass++;
    n_total++; if (ram[16] !== 16'h7041) $display("FAIL wr_ram: got %h want 7041", ram[16]); else n_pass++;
  endtask

  task automatic test_read();
    cmd = 6'b010011; addr = 16'h0010; wdata = 16'h0000;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd1) $display("FAIL rd_issue_state: got %0d want 1", state); else n_pass++;
    n_total++; if (mem_addr !== 14'h0010) $display("FAIL rd_mem_addr: got %h want 0010", mem_addr); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we: got %b want 0", mem_we); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd1) $display("FAIL rd_wait_state: got %0d want 1", state); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd2) $display("FAIL rd_done_state: got %0d want 2", state); else n_pass++;
    n_total++; if (rdata !== 16'h7041) $display("FAIL rd_rdata: got %h want 7041", rdata); else n_pass++;
    cmd = '0;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL rd_back_idle: got %0d want 0", state); else n_pass++;
    n_total++; if (rdata !== 16'h7041) $display("FAIL rd_rdata_hold: got %h want 7041", rdata); else n_pass++;
  endtask

  task automatic test_vid_block();
    wr_cnt = 0; viol_cnt = 0;
    cmd = 6'b100011; addr = 16'h0020; wdata = 16'h1234;
    vid_rd_en = 1'b1; vid_addr = 14'h0010;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1;
      n_total++; if (state !== 2'd1) $display("FAIL vid_state_%0d: got %0d want 1", i, state); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL vid_we_%0d: got %b want 0", i, mem_we); else n_pass++;
      n_total++; if (vid_valid !== 1'b1) $display("FAIL vid_valid_%0d: got %b want 1", i, vid_valid); else n_pass++;
      n_total++; if (vid_data !== 16'h7041) $display("FAIL vid_data_%0d: got %h want 7041", i, vid_data); else n_pass++;
    end
    @(negedge clk);
    vid_rd_en = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL vid_free_we: got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 14'h0020) $display("FAIL vid_free_addr: got %h want 0020", mem_addr); else n_pass++;
    n_total++; if (mem_din !== 16'h1234) $display("FAIL vid_free_din: got %h want 1234", mem_din); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd2) $display("FAIL vid_done: got %0d want 2", state); else n_pass++;
    n_total++; if (vid_valid !== 1'b0) $display("FAIL vid_valid_low: got %b want 0", vid_valid); else n_pass++;
    n_total++; if (vid_data !== 16'h7041) $display("FAIL vid_data_hold: got %h want 7041", vid_data); else n_pass++;
    cmd = '0;
    @(negedge clk); #1;
    n_total++; if (wr_cnt !== 1) $display("FAIL vid_wr_count: got %0d want 1", wr_cnt); else n_pass++;
    n_total++; if (viol_cnt !== 0) $display("FAIL vid_conflict: got %0d want 0", viol_cnt); else n_pass++;
    n_total++; if (ram[32] !== 16'h1234) $display("FAIL vid_ram: got %h want 1234", ram[32]); else n_pass++;
  endtask

  task automatic test_ignored_cmd();
    wr_cnt = 0;
    cmd = 6'b000011; addr = 16'h0050; wdata = 16'hFFFF;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL ign_state_a: got %0d want 0", state); else n_pass++;
    cmd = 6'b100000;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL ign_state_b: got %0d want 0", state); else n_pass++;
    n_total++; if (wr_cnt !== 0) $display("FAIL ign_writes: got %0d want 0", wr_cnt); else n_pass++;
    cmd = '0;
    @(negedge clk);
  endtask

  task automatic test_done_hold();
    wr_cnt = 0;
    cmd = 6'b100011; addr = 16'h0040; wdata = 16'hABCD;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (state !== 2'd2) $display("FAIL hold_done: got %0d want 2", state); else n_pass++;
    cmd = 6'b010011;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (state !== 2'd2) $display("FAIL hold_newcmd: got %0d want 2", state); else n_pass++;
    n_total++; if (wr_cnt !== 1) $display("FAIL hold_writes: got %0d want 1", wr_cnt); else n_pass++;
    cmd = '0;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL hold_release: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_cmd_drop();
    cmd = 6'b100011; addr = 16'h0030; wdata = 16'h5555; vid_rd_en = 1'b1; vid_addr = 14'h0000;
    @(negedge clk);
    cmd = '0; addr = 16'h0099; wdata = 16'h0000;
    @(negedge clk);
    vid_rd_en = 1'b0;
    #1;
    n_total++; if (state !== 2'd1) $display("FAIL drop_busy: got %0d want 1", state); else n_pass++;
    n_total++; if (mem_we !== 1'b1 || mem_addr !== 14'h0030) $display("FAIL drop_write: got we=%b addr=%h want we=1 addr=0030", mem_we, mem_addr); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd2) $display("FAIL drop_done: got %0d want 2", state); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL drop_idle: got %0d want 0", state); else n_pass++;
    n_total++; if (ram[48] !== 16'h5555) $display("FAIL drop_ram: got %h want 5555", ram[48]); else n_pass++;
  endtask

  task automatic test_oor();
    wr_cnt = 0;
    cmd = 6'b100011; addr = 16'h8010; wdata = 16'hDEAD;
    @(negedge clk); #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL oorw_we: got %b want 0", mem_we); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd2) $display("FAIL oorw_done: got %0d want 2", state); else n_pass++;
    cmd = '0;
    @(negedge clk); #1;
    n_total++; if (wr_cnt !== 0 || ram[16] !== 16'h7041) $display("FAIL oorw_nowrite: got cnt=%0d ram=%h want cnt=0 ram=7041", wr_cnt, ram[16]); else n_pass++;
    cmd = 6'b010011; addr = 16'h4000;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd1 || mem_we !== 1'b0) $display("FAIL oorr_issue: got st=%0d we=%b want st=1 we=0", state, mem_we); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (state !== 2'd2) $display("FAIL oorr_done: got %0d want 2", state); else n_pass++;
    n_total++; if (rdata !== 16'h0000) $display("FAIL oorr_rdata: got %h want 0000", rdata); else n_pass++;
    cmd = '0;
    @(negedge clk);
  endtask

  task automatic run_clear(input bit toggle_vid, input string tag);
    int cyc;
    cyc = 0;
    while (state !== 2'd2 && cyc < 6000) begin
      @(negedge clk);
      if (toggle_vid) begin
        vid_rd_en = ~vid_rd_en;
        vid_addr  = vid_addr + 14'd7;
      end
      #1;
      cyc++;
    end
    n_total++; if (state !== 2'd2) $display("FAIL %s_timeout: got state %0d want 2", tag, state); else n_pass++;
    n_total++; if (wr_cnt !== 2400) $display("FAIL %s_count: got %0d want 2400", tag, wr_cnt); else n_pass++;
    n_total++; if (clr_bad !== 0) $display("FAIL %s_sequence: got %0d bad writes want 0", tag, clr_bad); else n_pass++;
    n_total++; if (viol_cnt !== 0) $display("FAIL %s_vid_conflict: got %0d want 0", tag, viol_cnt); else n_pass++;
    n_total++; if (last_wa !== 14'd2399) $display("FAIL %s_last_addr: got %0d want 2399", tag, last_wa); else n_pass++;
    clr_mode = 1'b0; vid_rd_en = 1'b0; cmd = '0;
    @(negedge clk); #1;
    n_total++; if (state !== 2'd0) $display("FAIL %s_idle: got %0d want 0", tag, state); else n_pass++;
  endtask

  task automatic test_clear();
    wr_cnt = 0; viol_cnt = 0; clr_bad = 0; clr_next = 0; clr_mode = 1'b1;
    cmd = 6'b110000; vid_rd_en = 1'b0; vid_addr = 14'h0100;
    run_clear(1'b1, "clr");
  endtask

  task automatic test_reset_mid_clear();
    int snap;
    wr_cnt = 0; viol_cnt = 0; clr_bad = 0; clr_next = 0; clr_mode = 1'b1;
    cmd = 6'b110000; vid_rd_en = 1'b0;
    repeat (101) @(negedge clk);
    #1;
    n_total++; if (mem_addr !== 14'd100 || wr_cnt !== 100) $display("FAIL mid_counter: got addr=%0d cnt=%0d want 100/100", mem_addr, wr_cnt); else n_pass++;
    nrst = 1'b0; cmd = '0;
    #1;
    n_total++; if (state !== 2'd0) $display("FAIL mid_rst_state: got %0d want 0", state); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL mid_rst_we: got %b want 0", mem_we); else n_pass++;
    snap = wr_cnt;
    repeat (3) @(negedge clk);
    n_total++; if (wr_cnt !== snap) $display("FAIL mid_no_writes: got %0d want %0d", wr_cnt, snap); else n_pass++;
    nrst = 1'b1;
    @(negedge clk);
    wr_cnt = 0; clr_bad = 0; clr_next = 0;
    cmd = 6'b110000;
    @(negedge clk); #1;
    n_total++; if (mem_we !== 1'b1 || mem_addr !== 14'd0) $display("FAIL mid_restart: got we=%b addr=%0d want we=1 addr=0", mem_we, mem_addr); else n_pass++;
    run_clear(1'b0, "reclr");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_vid_block();
    test_ignored_cmd();
    test_done_hold();
    test_cmd_drop();
    test_oor();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
